// File: rtl/bsg_fifo_to_m_axi_lite_sync.sv
// Bridges a single-outstanding command/response FIFO interface onto an AXI4-Lite manager port.
// Tracks non-OKAY responses in a saturating error counter.
module bsg_fifo_to_m_axi_lite_sync #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int err_count_width_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic                         w_i,
    input  logic [addr_width_p-1:0]      addr_i,
    input  logic [data_width_p-1:0]      data_i,
    input  logic [data_width_p/8-1:0]    wstrb_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [data_width_p-1:0]      data_o,
    output logic [1:0]                   resp_o,
    input  logic                         yumi_i,
    output logic [addr_width_p-1:0]      awaddr_o,
    output logic [2:0]                   awprot_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    output logic [data_width_p-1:0]      wdata_o,
    output logic [data_width_p/8-1:0]    wstrb_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    input  logic [1:0]                   bresp_i,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    output logic [addr_width_p-1:0]      araddr_o,
    output logic [2:0]                   arprot_o,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    input  logic [data_width_p-1:0]      rdata_i,
    input  logic [1:0]                   rresp_i,
    input  logic                         rvalid_i,
    output logic                         rready_o,
    output logic [err_count_width_p-1:0] err_count_o
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_e;

    state_e                         state_q, state_d;
    logic [addr_width_p-1:0]        addr_q;
    logic [data_width_p-1:0]        wdata_q, data_q;
    logic [data_width_p/8-1:0]      wstrb_q;
    logic [1:0]                     resp_q;
    logic                           awvalid_q, wvalid_q;
    logic [err_count_width_p-1:0]   err_q, err_d;

    logic accept, b_cap, r_cap;
    logic [1:0] cap_resp;

    assign accept   = v_i & ready_o;
    assign b_cap    = (state_q == WR_RESP) & bvalid_i;
    assign r_cap    = (state_q == RD_RESP) & rvalid_i;
    assign cap_resp = b_cap ? bresp_i : rresp_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (v_i)        state_d = w_i ? WR_REQ : RD_REQ;
            WR_REQ:  if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i))
                                     state_d = WR_RESP;
            WR_RESP: if (bvalid_i)   state_d = RESP;
            RD_REQ:  if (arready_i)  state_d = RD_RESP;
            RD_RESP: if (rvalid_i)   state_d = RESP;
            RESP:    if (yumi_i)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ready_o is gated by reset so the FIFO side sees no accept while reset is held.
    always_comb begin
        ready_o   = 1'b0;
        bready_o  = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        v_o       = 1'b0;
        unique case (state_q)
            IDLE:    ready_o   = reset_n_i;
            WR_RESP: bready_o  = 1'b1;
            RD_REQ:  arvalid_o = 1'b1;
            RD_RESP: rready_o  = 1'b1;
            RESP:    v_o       = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if ((b_cap || r_cap) && (cap_resp != 2'b00) && (err_q != '1))
            err_d = err_q + err_count_width_p'(1);
    end

    // NOTE: the captured payload registers are reset too, so a reset leaves data_o/resp_o at zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            data_q    <= '0;
            resp_q    <= 2'b00;
            err_q     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= data_i;
                wstrb_q <= wstrb_i;
            end
            if (accept)         awvalid_q <= w_i;
            else if (awready_i) awvalid_q <= 1'b0;
            if (accept)         wvalid_q  <= w_i;
            else if (wready_i)  wvalid_q  <= 1'b0;
            if (b_cap) begin
                data_q <= '0;
                resp_q <= bresp_i;
            end else if (r_cap) begin
                data_q <= rdata_i;
                resp_q <= rresp_i;
            end
            err_q <= err_d;
        end
    end

    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign awprot_o    = 3'b000;
    assign arprot_o    = 3'b000;
    assign data_o      = data_q;
    assign resp_o      = resp_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_bsg_fifo_to_m_axi_lite_sync.sv
// Scoreboard bench: a configurable-stall AXI-Lite subordinate plus per-scenario tasks.
module tb_bsg_fifo_to_m_axi_lite_sync;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [31:0] addr_i = '0, data_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        ready_o, v_o;
    logic [31:0] data_o;
    logic [1:0]  resp_o;
    logic [31:0] awaddr_o, wdata_o, araddr_o;
    logic [2:0]  awprot_o, arprot_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
    logic        awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
    logic        arready_i = 1'b0, rvalid_i = 1'b0;
    logic [1:0]  bresp_i = 2'b00, rresp_i = 2'b00;
    logic [31:0] rdata_i = '0;
    logic [7:0]  err_count_o;

    int total = 0, bad = 0;
    exp_t exp_q[$];
    int exp_err = 0;

    bit          auto_sub = 1'b1;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          b_hs = 0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = '0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    bsg_fifo_to_m_axi_lite_sync dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .wstrb_i(wstrb_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .resp_o(resp_o), .yumi_i(yumi_i),
        .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    // Subordinate model and valid-stability monitor, both acting on the falling edge.
    always @(negedge clk) begin
        if (!reset_n_i) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
            if (auto_sub) begin
                awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
            end
        end else begin
            if (p_awv && !p_awr) begin
                total++;
                if (awvalid_o !== 1'b1 || awaddr_o !== p_awaddr) begin
                    bad++;
                    $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 %h", awvalid_o, awaddr_o, p_awaddr);
                end
            end
            if (p_wv && !p_wr) begin
                total++;
                if (wvalid_o !== 1'b1 || wdata_o !== p_wdata) begin
                    bad++;
                    $display("FAIL w_stable: wvalid=%b wdata=%h, required 1 %h", wvalid_o, wdata_o, p_wdata);
                end
            end
            if (p_arv && !p_arr) begin
                total++;
                if (arvalid_o !== 1'b1 || araddr_o !== p_araddr) begin
                    bad++;
                    $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 %h", arvalid_o, araddr_o, p_araddr);
                end
            end
            if (auto_sub) begin
                if (awvalid_o) begin awready_i = (aw_cnt == aw_wait); aw_cnt++; end
                else begin awready_i = 0; aw_cnt = 0; end
                if (wvalid_o) begin wready_i = (w_cnt == w_wait); w_cnt++; end
                else begin wready_i = 0; w_cnt = 0; end
                if (arvalid_o) begin arready_i = (ar_cnt == ar_wait); ar_cnt++; end
                else begin arready_i = 0; ar_cnt = 0; end
                if (bready_o) begin
                    bvalid_i = (b_cnt == b_wait);
                    if (bvalid_i) b_hs++;
                    b_cnt++;
                end else begin bvalid_i = 0; b_cnt = 0; end
                if (rready_o) begin rvalid_i = (r_cnt == r_wait); r_cnt++; end
                else begin rvalid_i = 0; r_cnt = 0; end
                bresp_i = bresp_val;
                rresp_i = rresp_val;
                rdata_i = rdata_val;
            end
            p_awv = awvalid_o; p_awr = awready_i; p_awaddr = awaddr_o;
            p_wv  = wvalid_o;  p_wr  = wready_i;  p_wdata  = wdata_o;
            p_arv = arvalid_o; p_arr = arready_i; p_araddr = araddr_o;
        end
    end

    // Presents one command and returns at the falling edge of the first cycle after accept.
    task automatic issue(input bit w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        @(negedge clk);
        v_i = 1'b1; w_i = w; addr_i = addr; data_i = data; wstrb_i = strb;
        while (ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
            v_i = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{data: exp_data, resp: exp_resp});
        @(negedge clk);
        v_i = 1'b0;
    endtask

    // Waits for v_o, checks it against the scoreboard, holds off yumi_i for `hold` cycles.
    task automatic wait_resp(input int hold, output int lat);
        exp_t e;
        lat = 0;
        while (v_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        total++;
        if (v_o !== 1'b1) begin
            bad++;
            $display("FAIL resp_timeout: v_o=%b after %0d cycles, required 1", v_o, lat);
            return;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp: data_o=%h with empty scoreboard, required none", data_o);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        if (e.resp != 2'b00 && exp_err < 255) exp_err++;
        total++;
        if (data_o !== e.data || resp_o !== e.resp) begin
            bad++;
            $display("FAIL resp_payload: data=%h resp=%b, required %h %b", data_o, resp_o, e.data, e.resp);
        end
        total++;
        if (err_count_o !== 8'(exp_err)) begin
            bad++;
            $display("FAIL err_count: got %0d, required %0d", err_count_o, exp_err);
        end
        repeat (hold) begin
            @(negedge clk);
            total++;
            if (v_o !== 1'b1 || data_o !== e.data || resp_o !== e.resp || ready_o !== 1'b0) begin
                bad++;
                $display("FAIL resp_hold: v=%b data=%h resp=%b ready=%b, required 1 %h %b 0",
                         v_o, data_o, resp_o, ready_o, e.data, e.resp);
            end
        end
        yumi_i = 1'b1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL ready_during_yumi: got %b, required 0", ready_o);
        end
        @(negedge clk);
        yumi_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            bad++;
            $display("FAIL after_yumi: ready=%b v=%b, required 1 0", ready_o, v_o);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ready_o, v_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o} !== 7'b0 ||
            err_count_o !== 8'd0 || data_o !== 32'd0 || resp_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: rdy=%b v=%b aw=%b w=%b ar=%b b=%b r=%b err=%0d data=%h, required all 0",
                     ready_o, v_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, err_count_o, data_o);
        end
        total++;
        if (awprot_o !== 3'b000 || arprot_o !== 3'b000) begin
            bad++;
            $display("FAIL prot: aw=%b ar=%b, required 000 000", awprot_o, arprot_o);
        end
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b, required 1", ready_o);
        end
    endtask

    task automatic test_write_zero_wait();
        int lat;
        aw_wait = 0; w_wait = 0; b_wait = 0; bresp_val = 2'b00;
        issue(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00);
        total++;
        if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1 || awaddr_o !== 32'h10 ||
            wdata_o !== 32'hCAFE_F00D || wstrb_o !== 4'hF) begin
            bad++;
            $display("FAIL wr_cycle1: awv=%b wv=%b addr=%h data=%h strb=%h, required 1 1 10 cafef00d f",
                     awvalid_o, wvalid_o, awaddr_o, wdata_o, wstrb_o);
        end
        wait_resp(0, lat);
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL wr_latency: v_o at cycle %0d, required 3", lat + 1);
        end
    endtask

    task automatic test_write_aw_delay();
        int lat;
        aw_wait = 3; w_wait = 0; b_wait = 0; b_hs = 0;
        issue(1'b1, 32'h24, 32'h1357_9BDF, 4'h5, 32'h0, 2'b00);
        total++;
        if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1) begin
            bad++;
            $display("FAIL awd_cycle1: awv=%b wv=%b, required 1 1", awvalid_o, wvalid_o);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (awvalid_o !== 1'b1 || wvalid_o !== 1'b0 || awaddr_o !== 32'h24 || bready_o !== 1'b0) begin
                bad++;
                $display("FAIL awd_cycle%0d: awv=%b wv=%b addr=%h bready=%b, required 1 0 24 0",
                         c, awvalid_o, wvalid_o, awaddr_o, bready_o);
            end
        end
        @(negedge clk);
        total++;
        if (awvalid_o !== 1'b0 || bready_o !== 1'b1) begin
            bad++;
            $display("FAIL awd_cycle5: awv=%b bready=%b, required 0 1", awvalid_o, bready_o);
        end
        wait_resp(0, lat);
        total++;
        if (b_hs != 1) begin
            bad++;
            $display("FAIL awd_b_count: got %0d, required 1", b_hs);
        end
        aw_wait = 0;
    endtask

    task automatic test_read_yumi_hold();
        int lat;
        ar_wait = 0; r_wait = 2; rdata_val = 32'h1234_5678; rresp_val = 2'b00;
        issue(1'b0, 32'h4, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 2'b00);
        total++;
        if (arvalid_o !== 1'b1 || araddr_o !== 32'h4 || awvalid_o !== 1'b0 || wvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_cycle1: arv=%b addr=%h awv=%b wv=%b, required 1 4 0 0",
                     arvalid_o, araddr_o, awvalid_o, wvalid_o);
        end
        wait_resp(5, lat);
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL rd_latency: v_o at cycle %0d, required 5", lat + 1);
        end
        r_wait = 0;
    endtask

    task automatic test_err_saturate();
        int lat;
        rresp_val = 2'b10;
        for (int i = 0; i < 257; i++) begin
            rdata_val = 32'hA000_0000 + 32'(i);
            issue(1'b0, 32'(i * 4), 32'h0, 4'h0, rdata_val, 2'b10);
            wait_resp(0, lat);
        end
        total++;
        if (err_count_o !== 8'd255) begin
            bad++;
            $display("FAIL err_saturated: got %0d, required 255", err_count_o);
        end
        rresp_val = 2'b00;
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        r_wait = 100000;
        issue(1'b0, 32'h80, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00);
        while (rready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (rready_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_reach_rd_resp: rready=%b, required 1", rready_o);
        end
        reset_n_i = 1'b0;
        #1;
        total++;
        if ({ready_o, v_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o} !== 7'b0 ||
            err_count_o !== 8'd0 || data_o !== 32'd0) begin
            bad++;
            $display("FAIL rst_async: rdy=%b v=%b ar=%b r=%b err=%0d data=%h, required 0 0 0 0 0 0",
                     ready_o, v_o, arvalid_o, rready_o, err_count_o, data_o);
        end
        exp_q.delete();
        exp_err = 0;
        auto_sub = 1'b0;
        rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        rdata_i = 32'hBAD0_BAD0; rresp_i = 2'b11; rvalid_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_ready: got %b, required 1", ready_o);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (v_o !== 1'b0 || ready_o !== 1'b1 || err_count_o !== 8'd0 || data_o !== 32'd0) begin
                bad++;
                $display("FAIL rst_late_rvalid: v=%b ready=%b err=%0d data=%h, required 0 1 0 0",
                         v_o, ready_o, err_count_o, data_o);
            end
        end
        rvalid_i = 1'b0;
        auto_sub = 1'b1;
        r_wait = 0;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] d;
        for (int round = 0; round < 4; round++) begin
            for (int k = 0; k < 3; k++) begin
                aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
                b_wait  = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
                r_wait  = $urandom_range(0, 3);
                if (k == 1) begin
                    rdata_val = $urandom; rresp_val = 2'($urandom_range(0, 3));
                    issue(1'b0, 32'h100 + 32'(round * 16), 32'h0, 4'h0, rdata_val, rresp_val);
                end else begin
                    d = $urandom; bresp_val = 2'($urandom_range(0, 3));
                    issue(1'b1, 32'h200 + 32'(round * 16 + k), d, 4'($urandom_range(0, 15)), 32'h0, bresp_val);
                end
                wait_resp($urandom_range(0, 2), lat);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_leftover: %0d responses missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read_yumi_hold();
        test_err_saturate();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_to_m_axi_lite_sync.md
BSG_FIFO_TO_M_AXI_LITE_SYNC -- requirements
Module: bsg_fifo_to_m_axi_lite_sync

Interface
REQ-001 Parameter addr_width_p, default 32, AXI/command address width.
REQ-002 Parameter data_width_p, default 32, AXI/command data width; wstrb width = data_width_p/8.
REQ-003 Parameter err_count_width_p, default 8, width of the error counter.
REQ-004 clk_i  in  1  single clock for all logic.
REQ-005 reset_n_i  in  1  reset; asynchronous assert, active-low.
REQ-006 v_i  in  1  command valid.
REQ-007 w_i  in  1  command type: 1 = write, 0 = read.
REQ-008 addr_i  in  addr_width_p  command address.
REQ-009 data_i  in  data_width_p  write data (ignored for reads).
REQ-010 wstrb_i  in  data_width_p/8  write byte strobes.
REQ-011 ready_o  out  1  command accept; handshake is v_i & ready_o.
REQ-012 v_o, data_o [data_width_p], resp_o [2]  out  response valid, read data, AXI resp code.
REQ-013 yumi_i  in  1  response consume; legal only while v_o=1.
REQ-014 AXI4-Lite manager outputs: awaddr_o, awprot_o[3], awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o, araddr_o, arprot_o[3], arvalid_o, rready_o.
REQ-015 AXI4-Lite manager inputs: awready_i, wready_i, bresp_i[2], bvalid_i, arready_i, rdata_i, rresp_i[2], rvalid_i.
REQ-016 err_count_o  out  err_count_width_p  saturating count of non-OKAY responses.

Function
REQ-017 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP; exactly one transaction outstanding.
REQ-018 ready_o = 1 only in IDLE; on accept, capture addr/data/wstrb/w_i; go to WR_REQ if w_i = 1, else RD_REQ.
REQ-019 WR_REQ: awvalid_o and wvalid_o both rise the cycle after accept; each drops the cycle after its own handshake (awvalid_o&awready_i, wvalid_o&wready_i); AW and W may complete in either order or together.
REQ-020 Leave WR_REQ for WR_RESP the cycle after both AW and W have completed; valids never reassert for the same transaction.
REQ-021 WR_RESP: bready_o = 1; on bvalid_i capture bresp_i, set data_o = 0, go to RESP; bready_o = 0 in all other states.
REQ-022 RD_REQ: arvalid_o = 1 until arready_i, then go to RD_RESP.
REQ-023 RD_RESP: rready_o = 1; on rvalid_i capture rdata_i and rresp_i, go to RESP; rready_o = 0 in all other states.
REQ-024 RESP: v_o = 1 with data_o/resp_o held stable; on yumi_i return to IDLE; ready_o stays 0 in the cycle yumi_i is asserted.
REQ-025 AXI valids are registered and, once asserted, stay asserted with stable payload until their handshake completes.
REQ-026 awprot_o = arprot_o = 3'b000 constant.
REQ-027 Minimum latency: command accept (cycle 0) -> AXI valid (cycle 1) -> v_o (cycle 3) when the subordinate responds with zero wait.
REQ-028 err_count_o increments by 1 on each captured bresp_i/rresp_i != 2'b00 and saturates at all-ones without wrapping.
REQ-029 bvalid_i/rvalid_i arriving outside WR_RESP/RD_RESP are ignored (not captured).

Reset
REQ-030 reset_n_i low asynchronously forces state IDLE, err_count_o = 0, captured registers = 0, v_o = 0, and all AXI valid/ready outputs = 0.
REQ-031 ready_o is 0 while reset_n_i is low and 1 in the first clock after release.
REQ-032 Reset mid-transaction abandons it: no response is produced, and a late bvalid_i/rvalid_i is ignored.

Verification
REQ-033 Write addr 0x10, data 0xCAFEF00D, wstrb 0xF, zero-wait subordinate -> AW/W valid at cycle 1, v_o at cycle 3, resp_o 00, data_o 0.
REQ-034 Write with awready_i delayed 3 cycles and wready_i immediate -> wvalid_o drops after cycle 1, awvalid_o held with addr stable until cycle 4, exactly one B accepted.
REQ-035 Read addr 0x4, rdata_i 0x12345678 after 2 wait cycles, yumi_i held off 5 cycles -> data_o 0x12345678 stable with v_o=1 the whole time, ready_o 0 until the cycle after yumi_i.
REQ-036 256 reads returning rresp 2'b10 with err_count_width_p = 8 -> err_count_o reaches 255 and stays at 255.
REQ-037 Assert reset_n_i low during RD_RESP, then drive rvalid_i after release -> outputs reset immediately, no v_o, ready_o=1, err_count_o=0.
REQ-038 Back-to-back write, read, write with random AXI stalls -> responses are in order, one per command, and AXI protocol checker is clean.
